// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter slice: RAM handshake state,
// arbiter FSM state, word/address typedefs and an index-width helper.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a core index; never zero so single-core builds still elaborate.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and RAM-side bus of the memory arbiter.
// slave: the arbiter's view; master: the cores + RAM model view.
interface mem_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCORES = 2,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32
);
    logic [NCORES-1:0]    iREN;
    logic [NCORES*AW-1:0] iaddr;
    logic [NCORES-1:0]    dREN;
    logic [NCORES-1:0]    dWEN;
    logic [NCORES*AW-1:0] daddr;
    logic [NCORES*DW-1:0] dstore;
    logic [NCORES-1:0]    iwait;
    logic [NCORES-1:0]    dwait;
    logic [NCORES*DW-1:0] iload;
    logic [NCORES*DW-1:0] dload;
    logic                 ramREN;
    logic                 ramWEN;
    logic [AW-1:0]        ramaddr;
    logic [DW-1:0]        ramstore;
    logic [DW-1:0]        ramload;
    ramstate_t            ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin picker: first requester after last_i, wrapping modulo NCORES.
// Purely combinational; returns one-hot grant and encoded index.
module rr_picker
    import cpu_types_pkg::*;
#(
    parameter  int unsigned NCORES = 2,
    localparam int unsigned IW     = idx_w(NCORES)
) (
    input  logic [NCORES-1:0] req_i,
    input  logic [IW-1:0]     last_i,
    output logic [NCORES-1:0] gnt_o,
    output logic [IW-1:0]     idx_o
);

    // Scan from last_i+1 round to last_i itself, keep the first hit.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NCORES; i++) begin
            cand = IW'((32'(last_i) + i) % NCORES);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the I/D channels of NCORES cores.
// Registered IDLE/GRANT FSM, data beats instruction, round-robin across cores.
// Optional build macro MEM_ARB_PERF_EN adds grant/stall counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCORES = 2,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    mem_arbiter_if.slave           bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NCORES*2*32-1:0] grant_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned IW = idx_w(NCORES);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     gnt_core_q, gnt_core_d;
    logic [IW-1:0]     last_core_q, last_core_d;
    logic              gnt_isdata_q, gnt_isdata_d;

    logic [NCORES-1:0] dreq;
    logic [NCORES-1:0] d_gnt, i_gnt;
    logic [IW-1:0]     d_idx, i_idx;

    logic              sel_iren, sel_dren, sel_dwen;
    logic [AW-1:0]     sel_iaddr, sel_daddr;
    logic [DW-1:0]     sel_dstore;
    logic              active, done;

    assign dreq = bus.dREN | bus.dWEN;

    rr_picker #(.NCORES(NCORES)) u_pick_d (
        .req_i  (dreq),
        .last_i (last_core_q),
        .gnt_o  (d_gnt),
        .idx_o  (d_idx)
    );

    rr_picker #(.NCORES(NCORES)) u_pick_i (
        .req_i  (bus.iREN),
        .last_i (last_core_q),
        .gnt_o  (i_gnt),
        .idx_o  (i_idx)
    );

    // Mux out the latched core's live request fields.
    always_comb begin
        sel_iren   = 1'b0;
        sel_dren   = 1'b0;
        sel_dwen   = 1'b0;
        sel_iaddr  = '0;
        sel_daddr  = '0;
        sel_dstore = '0;
        for (int unsigned c = 0; c < NCORES; c++) begin
            if (gnt_core_q == IW'(c)) begin
                sel_iren   = bus.iREN[c];
                sel_dren   = bus.dREN[c];
                sel_dwen   = bus.dWEN[c];
                sel_iaddr  = bus.iaddr[c*AW +: AW];
                sel_daddr  = bus.daddr[c*AW +: AW];
                sel_dstore = bus.dstore[c*DW +: DW];
            end
        end
    end

    // A grant is live only while its request line is still held; a drop aborts it.
    assign active = (state_q == GRANT) && (gnt_isdata_q ? (sel_dren | sel_dwen) : sel_iren);
    assign done   = active && ((bus.ramstate == ACCESS) || (bus.ramstate == ERROR));

    // State register; reset pulls everything back to IDLE immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            gnt_core_q   <= '0;
            gnt_isdata_q <= 1'b0;
            last_core_q  <= IW'(NCORES - 1);
        end else begin
            state_q      <= state_d;
            gnt_core_q   <= gnt_core_d;
            gnt_isdata_q <= gnt_isdata_d;
            last_core_q  <= last_core_d;
        end
    end

    // Next state: latch a winner from IDLE, leave GRANT on completion or abort.
    always_comb begin
        state_d      = state_q;
        gnt_core_d   = gnt_core_q;
        gnt_isdata_d = gnt_isdata_q;
        last_core_d  = last_core_q;
        case (state_q)
            IDLE: begin
                if (|d_gnt) begin
                    state_d      = GRANT;
                    gnt_core_d   = d_idx;
                    gnt_isdata_d = 1'b1;
                    last_core_d  = d_idx;
                end else if (|i_gnt) begin
                    state_d      = GRANT;
                    gnt_core_d   = i_idx;
                    gnt_isdata_d = 1'b0;
                    last_core_d  = i_idx;
                end
            end
            GRANT: begin
                if (!active || done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RAM strobes from the live grant, one-cycle wait drop on completion.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        if (active) begin
            if (gnt_isdata_q) begin
                bus.ramaddr  = sel_daddr;
                bus.ramstore = sel_dstore;
                bus.ramWEN   = sel_dwen;
                bus.ramREN   = sel_dren & ~sel_dwen;
            end else begin
                bus.ramaddr  = sel_iaddr;
                bus.ramREN   = 1'b1;
            end
        end
        if (done) begin
            for (int unsigned c = 0; c < NCORES; c++) begin
                if (gnt_core_q == IW'(c)) begin
                    if (gnt_isdata_q) begin
                        bus.dwait[c]           = 1'b0;
                        bus.dload[c*DW +: DW]  = bus.ramload;
                    end else begin
                        bus.iwait[c]           = 1'b0;
                        bus.iload[c*DW +: DW]  = bus.ramload;
                    end
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [2*NCORES-1:0] req_vec, comp_vec;
    logic [31:0]         grant_cnt_q [2*NCORES];
    logic [31:0]         stall_cnt_q;

    // Requester view r = 2*core + isdata of pending and completing requests.
    always_comb begin
        req_vec  = '0;
        comp_vec = '0;
        for (int unsigned c = 0; c < NCORES; c++) begin
            req_vec[2*c]   = bus.iREN[c];
            req_vec[2*c+1] = dreq[c];
            if (done && (gnt_core_q == IW'(c))) begin
                if (gnt_isdata_q) comp_vec[2*c+1] = 1'b1;
                else              comp_vec[2*c]   = 1'b1;
            end
        end
    end

    // Saturating grant and stall counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned r = 0; r < 2*NCORES; r++) grant_cnt_q[r] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned r = 0; r < 2*NCORES; r++) begin
                if (comp_vec[r] && (grant_cnt_q[r] != '1)) grant_cnt_q[r] <= grant_cnt_q[r] + 32'd1;
            end
            if ((|(req_vec & ~comp_vec)) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Flatten counters onto the output ports.
    always_comb begin
        grant_cnt = '0;
        for (int unsigned r = 0; r < 2*NCORES; r++) grant_cnt[r*32 +: 32] = grant_cnt_q[r];
        stall_cnt = stall_cnt_q;
    end
`endif

endmodule
